// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream carrying FIFO words downstream, with frame marker and beat index.
interface fifo_stream_reader_if #(
    parameter int DW = 8,
    parameter int CW = 16
) ();
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [CW-1:0] beat_cnt;

    modport master (output m_data, m_valid, m_last, beat_cnt, input m_ready);
    modport slave  (input m_data, m_valid, m_last, beat_cnt, output m_ready);
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the single-clock FIFO: pops with 1-cycle read latency into a
// 2-entry skid buffer and presents the words as a BURST_LEN-framed valid/ready stream.
module fifo_stream_reader #(
    parameter int DW        = 8,
    parameter int BURST_LEN = 16,
    parameter int CW        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DW-1:0]         fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic                  flush,
    fifo_stream_reader_if.master  stream
);

    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    // head_reg is the presented word; tail_reg holds the word queued behind it
    logic [DW-1:0] head_reg, head_next;
    logic [DW-1:0] tail_reg, tail_next;
    logic [1:0]    cnt_reg, cnt_next;
    logic          infl_reg;
    logic [CW-1:0] beat_reg, beat_next;

    logic          valid;
    logic          pop;
    logic [2:0]    occ_after_pop;
    logic [1:0]    kept;

    assign valid = (cnt_reg != 2'd0);
    assign pop   = valid && stream.m_ready;

    // Words owned after this cycle's pop, counting the one still coming back from the FIFO
    assign occ_after_pop = {1'b0, cnt_reg} + {2'b00, infl_reg} - {2'b00, pop};
    assign kept          = cnt_reg - {1'b0, pop};

    assign fifo_rd = !rst && !flush && !fifo_empty && (occ_after_pop < 3'd2);

    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        cnt_next  = occ_after_pop[1:0];
        beat_next = beat_reg;
        if (pop) begin
            beat_next = (beat_reg == LAST_BEAT) ? '0 : beat_reg + CW'(1);
            if (cnt_reg == 2'd2) begin
                head_next = tail_reg;
            end
        end
        // Capture is keyed only on the in-flight flag, so gated-to-zero data is never taken
        if (infl_reg) begin
            if (kept == 2'd0) begin
                head_next = fifo_dout;
            end else begin
                tail_next = fifo_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg <= '0;
            tail_reg <= '0;
            cnt_reg  <= 2'd0;
            infl_reg <= 1'b0;
            beat_reg <= '0;
        end else if (flush) begin
            cnt_reg  <= 2'd0;
            infl_reg <= 1'b0;
            beat_reg <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            cnt_reg  <= cnt_next;
            infl_reg <= fifo_rd;
            beat_reg <= beat_next;
        end
    end

    assign stream.m_data   = head_reg;
    assign stream.m_valid  = valid;
    assign stream.m_last   = valid && (beat_reg == LAST_BEAT);
    assign stream.beat_cnt = beat_reg;

endmodule
